// File: rtl/dbg_cmd_seq.sv
// -----------------------------------------------------------------------------
// dbg_cmd_seq
//
// Purpose
//   Sequences register-access requests from two requesters onto the command
//   bus of a daisy-chain of debug cores. Each accepted request becomes an
//   address flit followed (for ordinary writes) by a data flit on the next
//   cycle. A request to register 4'hF is a commit and carries no data flit.
//   The two requesters share the bus through a round-robin arbiter.
//
// Handshake
//   Requests use valid/ready: a request is consumed only in a cycle where
//   reqN_TVALID and reqN_TREADY are both high. TREADY is combinational, is
//   raised for at most one requester, only while the sequencer is idle and
//   never while rst is high; a request withdrawn before that cycle is simply
//   never seen. The command bus has no ready: a flit is delivered in every
//   cycle where cmd_out_TVALID is high.
//
// Ports
//   clk              sole clock, rising edge
//   rst              synchronous, active-high reset
//   reqN_TADDR       {core_addr, reg_addr[3:0]} of requester N (N = 0, 1)
//   reqN_TDATA       register write value of requester N
//   reqN_TVALID      request valid of requester N
//   reqN_TREADY      request accepted this cycle (combinational)
//   cmd_out_TDATA    command flit (registered, holds value while idle)
//   cmd_out_TVALID   command flit valid (registered)
//   busy             high while a transaction is in flight (registered)
//   last_grant       index of the most recently accepted requester
//   txn_cnt          completed-transaction counter (only with the macro)
//
// Configuration
//   DBG_CMD_SEQ_CNT_EN  when defined, adds the 16-bit txn_cnt output. It
//                       increments the cycle after each transaction's final
//                       flit and wraps from 16'hFFFF to 0.
// -----------------------------------------------------------------------------
module dbg_cmd_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH+3:0]   req0_TADDR,
  input  logic [DATA_WIDTH-1:0]   req0_TDATA,
  input  logic                    req0_TVALID,
  output logic                    req0_TREADY,

  input  logic [ADDR_WIDTH+3:0]   req1_TADDR,
  input  logic [DATA_WIDTH-1:0]   req1_TDATA,
  input  logic                    req1_TVALID,
  output logic                    req1_TREADY,

  output logic [DATA_WIDTH-1:0]   cmd_out_TDATA,
  output logic                    cmd_out_TVALID,
  output logic                    busy,
`ifdef DBG_CMD_SEQ_CNT_EN
  output logic [15:0]             txn_cnt,
`endif
  output logic                    last_grant
);

  localparam int TADDR_W = ADDR_WIDTH + 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    ptr_q;        // 0: req0 favoured on contention
  logic                    commit_q;     // latched request targets reg 4'hF
  logic [DATA_WIDTH-1:0]   data_q;       // latched write value
  logic [DATA_WIDTH-1:0]   cmd_tdata_q;
  logic                    cmd_tvalid_q;
  logic                    busy_q;
  logic                    last_grant_q;

  logic                    grant0_d;
  logic                    grant1_d;
  logic                    take_d;
  logic [TADDR_W-1:0]      sel_addr_d;
  logic [DATA_WIDTH-1:0]   sel_data_d;
  logic [DATA_WIDTH-1:0]   sel_flit_d;

  // Round-robin arbitration. A lone valid requester always wins; when both
  // are valid the pointer decides. Nothing is granted outside IDLE or while
  // reset is asserted, so a request in the reset cycle is never consumed.
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      if (req0_TVALID && (!req1_TVALID || !ptr_q)) begin
        grant0_d = 1'b1;
      end else if (req1_TVALID) begin
        grant1_d = 1'b1;
      end
    end
  end

  assign take_d      = grant0_d | grant1_d;
  assign req0_TREADY = grant0_d;
  assign req1_TREADY = grant1_d;

  assign sel_addr_d = grant1_d ? req1_TADDR : req0_TADDR;
  assign sel_data_d = grant1_d ? req1_TDATA : req0_TDATA;

  // Address flit: request address zero-extended to the flit width, which
  // puts reg_addr in [3:0] and core_addr directly above it.
  always_comb begin
    sel_flit_d                = '0;
    sel_flit_d[TADDR_W-1:0]   = sel_addr_d;
  end

  // Sequencer FSM. Outputs are loaded one cycle ahead of the state they
  // belong to, so the flit for state ADDR is presented exactly while the
  // state register reads ADDR (and likewise for DATA).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      commit_q     <= 1'b0;
      data_q       <= '0;
      cmd_tdata_q  <= '0;
      cmd_tvalid_q <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_tvalid_q <= 1'b0;
          busy_q       <= 1'b0;
          if (take_d) begin
            commit_q     <= (sel_addr_d[3:0] == 4'hF);
            data_q       <= sel_data_d;
            last_grant_q <= grant1_d;
            // Pointer always moves to the requester that did not win.
            ptr_q        <= grant0_d;
            cmd_tdata_q  <= sel_flit_d;
            cmd_tvalid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (commit_q) begin
            // Commit ends after its address flit; TDATA keeps that flit.
            cmd_tvalid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            cmd_tdata_q  <= data_q;
            cmd_tvalid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_DATA;
          end
        end

        ST_DATA: begin
          cmd_tvalid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end

        default: begin
          cmd_tvalid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_out_TDATA  = cmd_tdata_q;
  assign cmd_out_TVALID = cmd_tvalid_q;
  assign busy           = busy_q;
  assign last_grant     = last_grant_q;

`ifdef DBG_CMD_SEQ_CNT_EN
  logic [15:0] txn_cnt_q;
  logic        txn_done_d;

  // The final flit of a transaction is on the bus while the FSM is in DATA,
  // or in ADDR for a commit; counting on that edge makes the new value
  // visible on the following cycle. Natural 16-bit wrap.
  assign txn_done_d = (state_q == ST_DATA) || (state_q == ST_ADDR && commit_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt_q <= '0;
    end else if (txn_done_d) begin
      txn_cnt_q <= txn_cnt_q + 16'd1;
    end
  end

  assign txn_cnt = txn_cnt_q;
`endif

endmodule

// File: tb/tb_dbg_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_dbg_cmd_seq
//
// Directed bench for dbg_cmd_seq. Stimulus tasks push the expected grant
// index and expected command flits into queues before driving a request; an
// independent monitor on the falling clock edge pops and compares whenever
// the DUT raises a TREADY or cmd_out_TVALID. Each expected flit also carries
// a timing tag: an address flit must follow its TREADY cycle directly, a data
// flit must follow the previous flit directly.
// -----------------------------------------------------------------------------
module tb_dbg_cmd_seq;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int TW = AW + 4;

  logic          clk;
  logic          rst;
  logic [TW-1:0] req0_TADDR;
  logic [DW-1:0] req0_TDATA;
  logic          req0_TVALID;
  logic          req0_TREADY;
  logic [TW-1:0] req1_TADDR;
  logic [DW-1:0] req1_TDATA;
  logic          req1_TVALID;
  logic          req1_TREADY;
  logic [DW-1:0] cmd_out_TDATA;
  logic          cmd_out_TVALID;
  logic          busy;
  logic          last_grant;
`ifdef DBG_CMD_SEQ_CNT_EN
  logic [15:0]   txn_cnt;
`endif

  dbg_cmd_seq #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_TADDR     (req0_TADDR),
    .req0_TDATA     (req0_TDATA),
    .req0_TVALID    (req0_TVALID),
    .req0_TREADY    (req0_TREADY),
    .req1_TADDR     (req1_TADDR),
    .req1_TDATA     (req1_TDATA),
    .req1_TVALID    (req1_TVALID),
    .req1_TREADY    (req1_TREADY),
    .cmd_out_TDATA  (cmd_out_TDATA),
    .cmd_out_TVALID (cmd_out_TVALID),
    .busy           (busy),
`ifdef DBG_CMD_SEQ_CNT_EN
    .txn_cnt        (txn_cnt),
`endif
    .last_grant     (last_grant)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ scoreboard
  // exp_q entry: {is_data_flit, flit}
  logic [DW:0] exp_q[$];
  logic        exp_grant_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prev_valid  = 1'b0;
  logic        prev_tready = 1'b0;
  logic [DW:0] mon_e;
  logic        mon_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: expected event missing or unexpected event seen (t=%0t)", name, $time);
  endtask

  // Record what a request must produce: its grant and its flit(s).
  task automatic expect_txn(input logic port, input logic [TW-1:0] addr,
                            input logic [DW-1:0] data);
    logic [DW-1:0] flit;
    flit = '0;
    flit[TW-1:0] = addr;
    exp_grant_q.push_back(port);
    exp_q.push_back({1'b0, flit});
    if (addr[3:0] != 4'hF) exp_q.push_back({1'b1, data});
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    if (rst && (req0_TVALID || req1_TVALID))
      check("tready_in_reset", {30'd0, req1_TREADY, req0_TREADY}, 32'd0);
    if (req0_TVALID && req1_TVALID)
      check("single_tready", {31'd0, req0_TREADY & req1_TREADY}, 32'd0);
    if (req0_TREADY || req1_TREADY) begin
      if (exp_grant_q.size() == 0) begin
        fail_now("unexpected_grant");
      end else begin
        mon_g = exp_grant_q.pop_front();
        check("grant_idx", {31'd0, req1_TREADY}, {31'd0, mon_g});
      end
    end
    if (cmd_out_TVALID) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_flit");
      end else begin
        mon_e = exp_q.pop_front();
        check("flit_data", cmd_out_TDATA, mon_e[DW-1:0]);
        if (mon_e[DW]) check("data_contig", {31'd0, prev_valid}, 32'd1);
        else           check("addr_latency", {31'd0, prev_tready}, 32'd1);
      end
    end
    prev_valid  = cmd_out_TVALID;
    prev_tready = req0_TREADY | req1_TREADY;
  end

  // ---------------------------------------------------------------- driver
  task automatic drive(input logic port, input logic [TW-1:0] addr,
                       input logic [DW-1:0] data, input logic vld);
    if (port) begin
      req1_TADDR = addr; req1_TDATA = data; req1_TVALID = vld;
    end else begin
      req0_TADDR = addr; req0_TDATA = data; req0_TVALID = vld;
    end
  endtask

  // Present one request, wait (bounded) for its TREADY, withdraw it.
  // Returns just after the edge that accepted it, i.e. in the ADDR cycle.
  task automatic issue(input logic port, input logic [TW-1:0] addr,
                       input logic [DW-1:0] data);
    int  budget;
    logic got;
    @(posedge clk); #1;
    drive(port, addr, data, 1'b1);
    budget = 0;
    got    = 1'b0;
    while (!got && budget < 20) begin
      @(negedge clk);
      budget++;
      got = port ? req1_TREADY : req0_TREADY;
    end
    if (!got) fail_now("grant_timeout");
    @(posedge clk); #1;
    drive(port, addr, data, 1'b0);
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    int g;
    int b;
    rst = 1'b1;
    req0_TADDR = '0; req0_TDATA = '0; req0_TVALID = 1'b0;
    req1_TADDR = '0; req1_TDATA = '0; req1_TVALID = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid",     {31'd0, cmd_out_TVALID}, 32'd0);
    check("rst_tdata",      cmd_out_TDATA, 32'd0);
    check("rst_busy",       {31'd0, busy}, 32'd0);
    check("rst_last_grant", {31'd0, last_grant}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write from req0
    expect_txn(1'b0, {10'd3, 4'd2}, 32'hDEADBEEF);
    issue(1'b0, {10'd3, 4'd2}, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_busy_t1", {31'd0, busy}, 32'd1);
    check("wr_lg_t1",   {31'd0, last_grant}, 32'd0);
    @(negedge clk);
    check("wr_busy_t2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("wr_busy_t3",   {31'd0, busy}, 32'd0);
    check("wr_tvalid_t3", {31'd0, cmd_out_TVALID}, 32'd0);

    // Commit from req1: one flit, busy for one cycle
    expect_txn(1'b1, {10'd5, 4'hF}, 32'h0BAD0BAD);
    issue(1'b1, {10'd5, 4'hF}, 32'h0BAD0BAD);
    @(negedge clk);
    check("cm_busy_t1", {31'd0, busy}, 32'd1);
    check("cm_lg_t1",   {31'd0, last_grant}, 32'd1);
    @(negedge clk);
    check("cm_busy_t2",   {31'd0, busy}, 32'd0);
    check("cm_tvalid_t2", {31'd0, cmd_out_TVALID}, 32'd0);
    check("cm_hold_t2",   cmd_out_TDATA, 32'h0000005F);

    // Lone req1 again (reg 14 is an ordinary write); a req0 pulse that is
    // withdrawn while the sequencer is busy must never be granted.
    expect_txn(1'b1, {10'h3FF, 4'hE}, 32'h12345678);
    issue(1'b1, {10'h3FF, 4'hE}, 32'h12345678);
    drive(1'b0, {10'd7, 4'd7}, 32'hCAFEF00D, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, {10'd7, 4'd7}, 32'hCAFEF00D, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Contention: both valid continuously, four grants 0,1,0,1
    expect_txn(1'b0, {10'd1, 4'd1}, 32'hA0A0A0A0);
    expect_txn(1'b1, {10'd2, 4'd7}, 32'hB1B1B1B1);
    expect_txn(1'b0, {10'd1, 4'd1}, 32'hA0A0A0A0);
    expect_txn(1'b1, {10'd2, 4'd7}, 32'hB1B1B1B1);
    @(posedge clk); #1;
    drive(1'b0, {10'd1, 4'd1}, 32'hA0A0A0A0, 1'b1);
    drive(1'b1, {10'd2, 4'd7}, 32'hB1B1B1B1, 1'b1);
    g = 0;
    b = 0;
    while (g < 4 && b < 100) begin
      @(negedge clk);
      b++;
      if (req0_TREADY || req1_TREADY) g++;
    end
    if (g < 4) fail_now("contention_timeout");
    @(posedge clk); #1;
    req0_TVALID = 1'b0;
    req1_TVALID = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset during the ADDR cycle of a write: no data flit, both requesters
    // held valid through reset, req0 must win afterwards.
    exp_grant_q.push_back(1'b0);
    exp_q.push_back({1'b0, 32'h00000094});
    issue(1'b0, {10'd9, 4'd4}, 32'h55AA55AA);
    rst = 1'b1;
    drive(1'b0, {10'd7, 4'd3}, 32'h0F0F0F0F, 1'b1);
    drive(1'b1, {10'd8, 4'd3}, 32'h11111111, 1'b1);
    expect_txn(1'b0, {10'd7, 4'd3}, 32'h0F0F0F0F);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_tvalid", {31'd0, cmd_out_TVALID}, 32'd0);
    check("mid_rst_busy",   {31'd0, busy}, 32'd0);
    check("mid_rst_tdata",  cmd_out_TDATA, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    b = 0;
    while (!(req0_TREADY || req1_TREADY) && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (!(req0_TREADY || req1_TREADY)) fail_now("post_rst_timeout");
    @(posedge clk); #1;
    req0_TVALID = 1'b0;
    req1_TVALID = 1'b0;
    @(negedge clk);
    check("post_rst_lg", {31'd0, last_grant}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

`ifdef DBG_CMD_SEQ_CNT_EN
    // One write completed since the mid-write reset cleared the counter.
    @(negedge clk);
    check("cnt_after_rst", {16'd0, txn_cnt}, 32'd1);
    force dut.txn_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.txn_cnt_q;
    @(negedge clk);
    check("cnt_preload", {16'd0, txn_cnt}, 32'h0000FFFF);
    expect_txn(1'b0, {10'd2, 4'hF}, 32'd0);
    issue(1'b0, {10'd2, 4'hF}, 32'd0);
    @(negedge clk);
    check("cnt_before_wrap", {16'd0, txn_cnt}, 32'h0000FFFF);
    @(negedge clk);
    check("cnt_wrap", {16'd0, txn_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("flits_outstanding",  exp_q.size(), 32'd0);
    check("grants_outstanding", exp_grant_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of sequence");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dbg_cmd_seq.md
DBG_CMD_SEQ -- requirements
Module: dbg_cmd_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32: command flit width; SHALL be >= ADDR_WIDTH+4.
REQ-002 Parameter ADDR_WIDTH, default 10: debug-core address width.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- reqN_TADDR  in  ADDR_WIDTH+4  request address {core_addr, reg_addr[3:0]}, N=0,1.
- reqN_TDATA  in  DATA_WIDTH  register write value, N=0,1.
- reqN_TVALID  in  1  request valid, N=0,1.
- reqN_TREADY  out  1  request accepted this cycle, N=0,1.
- cmd_out_TDATA  out  DATA_WIDTH  command flit to daisy-chained debug cores.
- cmd_out_TVALID  out  1  flit valid; no backpressure exists on this bus.
- busy  out  1  high while a transaction is in flight (state != IDLE).
- last_grant  out  1  index of the most recently accepted requester.

Function
REQ-004 SHALL implement FSM states IDLE, ADDR, DATA; the state register and all outputs except reqN_TREADY SHALL be registered.
REQ-005 IDLE: if any reqN_TVALID is high, assert the winner's TREADY combinationally, latch its TADDR/TDATA, then go to ADDR on the next cycle.
REQ-006 Arbitration SHALL be round-robin: a priority pointer selects the winner when both requesters are valid; after any grant the pointer moves to the other requester; a lone valid requester always wins.
REQ-007 At most one reqN_TREADY SHALL be high in any cycle, and only in IDLE.
REQ-008 ADDR: cmd_out_TVALID=1 and cmd_out_TDATA = zero-extended {core_addr, reg_addr}, with reg_addr in bits [3:0] and core_addr in bits [ADDR_WIDTH+3:4].
REQ-009 A commit request (reg_addr = 4'hF) SHALL issue only the ADDR flit, then return to IDLE.
REQ-010 Any other reg_addr SHALL go ADDR->DATA; DATA drives the latched value with cmd_out_TVALID=1, then returns to IDLE.
REQ-011 The ADDR and DATA flits of one transaction SHALL be on consecutive cycles, and no flit from another transaction SHALL come between them.
REQ-012 Latency SHALL be: accept at cycle T -> address flit at T+1 -> data flit at T+2; a write takes 3 cycles and a commit 2 cycles.
REQ-013 cmd_out_TVALID SHALL be 0 in IDLE, and cmd_out_TDATA SHALL hold its last value there.
REQ-014 A reg_addr of 11..14 SHALL be sequenced like a write; it is not filtered.
REQ-015 A request deasserted before it is accepted SHALL be ignored; no request is consumed without a TREADY pulse.

Reset
REQ-016 When rst is sampled high, the block SHALL set: state=IDLE, cmd_out_TVALID=0, cmd_out_TDATA=0, busy=0, last_grant=0, priority pointer=0 (req0 favoured), reqN_TREADY=0 in that cycle.
REQ-017 Reset during ADDR or DATA SHALL abandon the transaction with no further flits. System reset of the debug cores returns their receive FSMs to the address phase.
REQ-018 A request presented in the reset cycle SHALL NOT be accepted.

Configuration
REQ-019 Macro DBG_CMD_SEQ_CNT_EN defined: add output txn_cnt [15:0], reset 0. It increments on the cycle after each transaction's final flit and wraps 16'hFFFF->0.
REQ-020 Macro DBG_CMD_SEQ_CNT_EN undefined: no txn_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-021 Single write: req0 TADDR={10'd3,4'd2}, TDATA=32'hDEADBEEF -> TREADY in cycle T; flits 32'h00000032 at T+1 and 32'hDEADBEEF at T+2; TVALID low at T+3.
REQ-022 Commit: req1 TADDR={10'd5,4'hF} -> one flit 32'h0000005F; busy high for exactly 1 cycle; last_grant=1.
REQ-023 Contention: both requesters valid continuously -> grants alternate 0,1,0,1 starting with req0 after reset; each write's flit pair stays contiguous; no double TREADY.
REQ-024 Reset mid-write: assert rst during the ADDR cycle -> no data flit; TVALID=0 next cycle; req0 wins the next contention.
REQ-025 With DBG_CMD_SEQ_CNT_EN: preload 65535 transactions (or force the counter) and complete one more -> txn_cnt wraps to 0; without the macro, elaboration has no txn_cnt port.
